string_receiver_serial: RTL
===========================

STRING_RECEIVER_SERIAL -- requirements
Module: string_receiver_serial

Interface
REQ-001 SHALL have parameter MAX_CHARS, default 16, giving the string capacity in characters.
REQ-002 SHALL have parameter CLK_FREQUENCY, default 100_000_000, giving the clock rate in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 19_200, giving the serial bit rate.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: start and hold string capture.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial in; idle high; 8N1; LSB first.
REQ-008 SHALL have port string_out, output, MAX_CHARS*8 bits: received ASCII; first character in the MSB byte.
REQ-009 SHALL have port char_count, output, $clog2(MAX_CHARS+1) bits: number of characters stored.
REQ-010 SHALL have port done, output, 1 bit: capture complete.
REQ-011 SHALL have port rx_error, output, 1 bit: sticky framing-error flag.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer (rx_sync); both flops reset to 1.
REQ-013 SHALL use BIT_PERIOD = CLK_FREQUENCY/BAUD_RATE cycles (integer division) and HALF_BIT = BIT_PERIOD/2.
REQ-014 SHALL implement a receiver FSM with states R_IDLE, R_START, R_DATA, R_STOP, R_BREAK, running regardless of enable.
REQ-015 SHALL, in R_IDLE, move to R_START on the first cycle rx_sync==0 (cycle t0) and clear the bit timer.
REQ-016 SHALL, in R_START at HALF_BIT cycles after t0, go to R_DATA if rx_sync==0; otherwise treat it as a glitch and go to R_IDLE with no byte produced.
REQ-017 SHALL, in R_DATA, sample rx_sync every BIT_PERIOD cycles into a shift register, LSB first; after 8 samples, go to R_STOP.
REQ-018 SHALL, in R_STOP, sample after BIT_PERIOD cycles: if 1, pulse byte_valid for exactly 1 cycle and go to R_IDLE; if 0, set rx_error, discard the byte and go to R_BREAK.
REQ-019 SHALL hold R_BREAK until rx_sync==1, then go to R_IDLE.
REQ-020 SHALL implement an assembler FSM with states ST_WAIT, ST_COLLECT, ST_DONE.
REQ-021 SHALL, in ST_WAIT with enable==1, fill string_out with 0x20, clear char_count and rx_error on that edge, and go to ST_COLLECT.
REQ-022 SHALL, on byte_valid in ST_COLLECT with a byte other than 0x0D, write the byte to string_out[(MAX_CHARS-char_count)*8-1 -: 8] on the next edge and increment char_count.
REQ-023 SHALL go to ST_DONE when the byte stored makes char_count==MAX_CHARS.
REQ-024 SHALL, on byte_valid in ST_COLLECT carrying 0x0D, store nothing, leave char_count unchanged, leave the remaining bytes at 0x20 and go to ST_DONE.
REQ-025 SHALL drive done=1 exactly while in ST_DONE, and return to ST_WAIT when enable==0.
REQ-026 SHALL return to ST_WAIT if enable==0 in ST_COLLECT, retaining string_out and char_count.
REQ-027 SHALL ignore byte_valid in ST_WAIT and ST_DONE; no change to string_out or char_count.
REQ-028 SHALL keep string_out and char_count stable except on the edges defined in REQ-021, REQ-022 and REQ-031.
REQ-029 SHALL never let char_count exceed MAX_CHARS.
REQ-030 SHALL keep rx_error set until reset or a new capture start (REQ-021).

Reset
REQ-031 SHALL, on reset==1 at a rising edge, put the receiver in R_IDLE and the assembler in ST_WAIT, set string_out to all 0x20, and set char_count=0, done=0, rx_error=0 and byte_valid=0; this SHALL abort any in-flight byte, take effect the next cycle, and take priority over all other events.

Verification
REQ-032 Bench parameters SHALL be CLK_FREQUENCY=160 and BAUD_RATE=10 (BIT_PERIOD=16, HALF_BIT=8).
REQ-033 Full string: enable=1, send "Hello World!1234" -> done=1 after the 16th stop bit; string_out[127:120]=0x48; string_out[7:0]=0x34; char_count=16; rx_error=0.
REQ-034 Early terminate: send 0x48, 0x69, 0x0D -> done=1; string_out[127:112]=0x4869; remaining 14 bytes=0x20; char_count=2.
REQ-035 Glitch: rx low for 4 cycles -> no byte_valid; char_count unchanged; receiver back in R_IDLE.
REQ-036 Framing error: 0x41 with stop bit 0, then 0x42 -> rx_error=1; string_out[127:120]=0x42; char_count=1.
REQ-037 Abort and restart: drop enable after 5 characters -> done=0 and char_count=5 held; re-raise enable -> string_out all 0x20, char_count=0; bytes sent while done=1 are ignored.
REQ-038 Reset mid-byte: reset during R_DATA -> reset values next cycle; a following 0x5A is received and stored correctly.

Source files
------------

// File: rtl/string_receiver_serial.sv
// string_receiver_serial: 8N1 UART receiver feeding a string assembler.
// Characters are packed first-character-in-MSB-byte into string_out; a
// carriage return (0x0D) or a full buffer ends the capture.
module string_receiver_serial #(
    parameter int MAX_CHARS     = 16,
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           rx,
    output logic [MAX_CHARS*8-1:0]         string_out,
    output logic [$clog2(MAX_CHARS+1)-1:0] char_count,
    output logic                           done,
    output logic                           rx_error,
    output logic [2:0]                     dbg_rx_state_o,
    output logic [1:0]                     dbg_asm_state_o
);

    localparam int BIT_PERIOD = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT   = BIT_PERIOD / 2;
    localparam int CW         = $clog2(MAX_CHARS + 1);
    localparam int TW         = $clog2(BIT_PERIOD + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(MAX_CHARS - 1);

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_START = 3'd1,
        R_DATA  = 3'd2,
        R_STOP  = 3'd3,
        R_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } asm_state_t;

    logic                   rx_s1_q;
    logic                   rx_s2_q;
    logic                   rx_sync;

    rx_state_t              rx_state_q;
    logic [TW-1:0]          timer_q;
    logic [2:0]             bit_cnt_q;
    logic [7:0]             shift_q;
    logic                   byte_valid_q;
    logic                   rx_error_q;

    asm_state_t             asm_state_q;
    logic [MAX_CHARS*8-1:0] string_q;
    logic [CW-1:0]          char_count_q;
    logic                   done_q;
    logic                   capture_start;

    // Handshake: byte_valid_q is a one-cycle strobe with no back-pressure;
    // shift_q holds the received byte while it is high (the receiver is idle
    // then), and the assembler must consume it in that same cycle or lose it.

    assign rx_sync       = rx_s2_q;
    assign capture_start = (asm_state_q == ST_WAIT) && enable;

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    // Receiver FSM: start-bit validation at mid-bit, 8 LSB-first samples, stop check.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q   <= R_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            rx_error_q   <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            // A new capture clears the sticky error; a framing error on the
            // same edge is written below and therefore wins.
            if (capture_start) begin
                rx_error_q <= 1'b0;
            end
            case (rx_state_q)
                R_IDLE: begin
                    timer_q   <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_sync) begin
                        rx_state_q <= R_START;
                    end
                end
                R_START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_q    <= '0;
                        rx_state_q <= rx_sync ? R_IDLE : R_DATA;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        shift_q <= {rx_sync, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q  <= '0;
                            rx_state_q <= R_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                R_STOP: begin
                    if (timer_q == BIT_LAST) begin
                        timer_q <= '0;
                        if (rx_sync) begin
                            byte_valid_q <= 1'b1;
                            rx_state_q   <= R_IDLE;
                        end else begin
                            rx_error_q <= 1'b1;
                            rx_state_q <= R_BREAK;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                R_BREAK: begin
                    if (rx_sync) begin
                        rx_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rx_state_q <= R_IDLE;
                end
            endcase
        end
    end

    // Assembler FSM: packs received bytes into the string until CR or full.
    always_ff @(posedge clk) begin
        if (reset) begin
            asm_state_q  <= ST_WAIT;
            string_q     <= {MAX_CHARS{8'h20}};
            char_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            case (asm_state_q)
                ST_WAIT: begin
                    done_q <= 1'b0;
                    if (enable) begin
                        string_q     <= {MAX_CHARS{8'h20}};
                        char_count_q <= '0;
                        asm_state_q  <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!enable) begin
                        asm_state_q <= ST_WAIT;
                    end else if (byte_valid_q) begin
                        if (shift_q == 8'h0D) begin
                            asm_state_q <= ST_DONE;
                            done_q      <= 1'b1;
                        end else begin
                            // Slot i sits at byte (MAX_CHARS-1-i) counting from the LSB.
                            for (int i = 0; i < MAX_CHARS; i++) begin
                                if (char_count_q == CW'(i)) begin
                                    string_q[(MAX_CHARS-i)*8-1 -: 8] <= shift_q;
                                end
                            end
                            char_count_q <= char_count_q + 1'b1;
                            if (char_count_q == LAST_SLOT) begin
                                asm_state_q <= ST_DONE;
                                done_q      <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!enable) begin
                        asm_state_q <= ST_WAIT;
                        done_q      <= 1'b0;
                    end
                end
                default: begin
                    asm_state_q <= ST_WAIT;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign string_out      = string_q;
    assign char_count      = char_count_q;
    assign done            = done_q;
    assign rx_error        = rx_error_q;
    assign dbg_rx_state_o  = rx_state_q;
    assign dbg_asm_state_o = asm_state_q;

endmodule
